// File: rtl/word_serializer.sv
// Parallel-in, serial-out word serializer: one signed word per frame, shifted
// out MSB-first under valid/ready back-pressure, with a frame_done pulse.
module word_serializer #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic signed [BUS_WIDTH-1:0] load_data,
  output logic                        ser_out,
  output logic                        ser_valid,
  input  logic                        ser_ready,
  output logic                        frame_start,
  output logic                        frame_done,
  output logic                        busy
);
  localparam int CW = $clog2(BUS_WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(BUS_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign beat = (state_q == SHIFT) && ser_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d = load_data;
          cnt_d   = CNT_MAX;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // load_valid is deliberately ignored here; the word in flight owns shreg
        if (beat) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            shreg_d = {shreg_q[BUS_WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_ready  = (state_q == IDLE);
  assign ser_valid   = (state_q == SHIFT);
  assign busy        = (state_q == SHIFT);
  assign ser_out     = (state_q == SHIFT) ? shreg_q[BUS_WIDTH-1] : 1'b0;
  assign frame_start = (state_q == SHIFT) && (cnt_q == CNT_MAX);
  assign frame_done  = done_q;
endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: per-cycle vector tables for the 8-bit
// instance plus hand sequences for async reset mid-frame and a 4-bit instance.
module tb_word_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       lv8, lr8, so8, sv8, sr8, fs8, fd8, bz8;
  logic [7:0] d8;
  // 4-bit instance
  logic       lv4, lr4, so4, sv4, sr4, fs4, fd4, bz4;
  logic [3:0] d4;

  word_serializer #(.BUS_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv8), .load_ready(lr8), .load_data(d8),
    .ser_out(so8), .ser_valid(sv8), .ser_ready(sr8), .frame_start(fs8),
    .frame_done(fd8), .busy(bz8));

  word_serializer #(.BUS_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv4), .load_ready(lr4), .load_data(d4),
    .ser_out(so4), .ser_valid(sv4), .ser_ready(sr4), .frame_start(fs4),
    .frame_done(fd4), .busy(bz4));

  // {ser_out, ser_valid, frame_start, frame_done, load_ready, busy}
  logic [5:0] o8;
  assign o8 = {so8, sv8, fs8, fd8, lr8, bz8};

  typedef struct {
    logic       lv;
    logic [7:0] d;
    logic       rdy;
    logic [5:0] exp;
    string      tag;
  } vec_t;

  vec_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [5:0] idle_e(logic fd);
    return {1'b0, 1'b0, 1'b0, fd, 1'b1, 1'b0};
  endfunction

  function automatic logic [5:0] shift_e(logic o, logic fs);
    return {o, 1'b1, fs, 1'b0, 1'b0, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (so,sv,fs,fd,lr,busy)", name, act, exp);
    end
  endtask

  task automatic add(input logic lv, input logic [7:0] d, input logic rdy,
                     input logic [5:0] exp, input string tag);
    vec_t v;
    v.lv = lv; v.d = d; v.rdy = rdy; v.exp = exp; v.tag = tag;
    q.push_back(v);
  endtask

  // One full frame: load cycle, BUS_WIDTH beats (optional stall before bit
  // stall_idx, optional intruding load during bit intr_idx), done pulse, idle.
  task automatic add_frame(input logic [7:0] w, input int stall_idx, input int stall_len,
                           input int intr_idx, input string tag);
    add(1'b1, w, 1'b0, idle_e(1'b0), {tag, "_load"});
    for (int i = 0; i < 8; i++) begin
      if (i == stall_idx)
        for (int s = 0; s < stall_len; s++)
          add(1'b0, 8'h00, 1'b0, shift_e(w[7-i], i == 0), $sformatf("%s_stall%0d", tag, s));
      add(i == intr_idx, (i == intr_idx) ? 8'hFF : 8'h00, 1'b1,
          shift_e(w[7-i], i == 0), $sformatf("%s_bit%0d", tag, i));
    end
    add(1'b0, 8'h00, 1'b0, idle_e(1'b1), {tag, "_done"});
    add(1'b0, 8'h00, 1'b0, idle_e(1'b0), {tag, "_after"});
  endtask

  task automatic run_table();
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      lv8 = q[i].lv; d8 = q[i].d; sr8 = q[i].rdy;
      chk(q[i].tag, o8, q[i].exp);
    end
    q.delete();
  endtask

  initial begin
    lv8 = 0; d8 = 0; sr8 = 0;
    lv4 = 0; d4 = 0; sr4 = 0;
    #1 chk("in_reset", o8, idle_e(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) add(1'b0, 8'h00, 1'b0, idle_e(1'b0), $sformatf("rst_idle%0d", i));
    add_frame(8'hA5, -1, 0, -1, "a5");
    add_frame(8'hFF, 3, 4, -1, "ff_stall");
    add_frame(8'h3C, -1, 0, 1, "3c_intr");
    // 0x80 frame, cut off by reset while bit 4 is presented
    add(1'b1, 8'h80, 1'b0, idle_e(1'b0), "80_load");
    for (int i = 0; i < 4; i++)
      add(1'b0, 8'h00, 1'b1, shift_e(i == 0, i == 0), $sformatf("80_bit%0d", i));
    add(1'b0, 8'h00, 1'b0, shift_e(1'b0, 1'b0), "80_bit4");
    run_table();

    rst_n = 1'b0;
    #1 chk("async_rst", o8, idle_e(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 1'b0, idle_e(1'b0), $sformatf("post_rst%0d", i));
    add_frame(8'h01, -1, 0, -1, "01");
    run_table();

    // BUS_WIDTH=4: 4'b1001 with ser_ready toggling
    begin
      logic [3:0] w4 = 4'b1001;
      int beats = 0, dones = 0, last_beat = -10, done_at = -1;
      @(negedge clk); lv4 = 1; d4 = w4;
      @(negedge clk); lv4 = 0; d4 = 0;
      for (int k = 0; k < 30; k++) begin
        sr4 = (k % 2 == 0);
        if (fd4) begin
          dones++;
          done_at = k;
        end
        if (sv4 && sr4) begin
          if (beats < 4)
            chk($sformatf("w4_bit%0d", beats), {so4, sv4, 4'b0}, {w4[3-beats], 1'b1, 4'b0});
          beats++;
          last_beat = k;
        end
        @(negedge clk);
      end
      sr4 = 0;
      checks++;
      if (beats != 4 || dones != 1 || done_at != last_beat + 1) begin
        errors++;
        $display("FAIL w4_frame: beats %0d dones %0d done_at %0d last_beat %0d, need 4 beats, 1 done at last_beat+1",
                 beats, dones, done_at, last_beat);
      end
      chk("w4_idle", {1'b0, sv4, fs4, fd4, lr4, bz4}, idle_e(1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
